// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared sizing constants and types for the data-memory arbiter.
//   DMEM_ADDR_W       - byte address width into data memory (512 B)
//   DMEM_DATA_W       - data word width
//   DMEM_ARB_MAX_WAIT - default refusal limit before the debug port is forced through
//   WaitCntW          - width of the starvation counter (covers MAX_WAIT up to 15)
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W       = 9;
  localparam int unsigned DMEM_DATA_W       = 16;
  localparam int unsigned DMEM_ARB_MAX_WAIT = 4;
  localparam int unsigned WaitCntW          = 4;

  // Which port owns the read response that is in flight.
  typedef enum logic {
    RspP0 = 1'b0,
    RspP1 = 1'b1
  } rsp_port_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of consecutive cycles the debug port was refused.
// Ports:
//   clk, rst (sync, active-high)
//   p1_req  - debug port request valid
//   p1_gnt  - debug port granted this cycle
//   force1  - refusal limit reached; debug port must win this cycle
module dmem_arb_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DMEM_ARB_MAX_WAIT  // 1..15
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_req,
  input  logic p1_gnt,
  output logic force1
);

  localparam logic [WaitCntW-1:0] MaxWait = WaitCntW'(MAX_WAIT);

  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force1 = (wait_cnt_q == MaxWait);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM stage (port 0,
// priority) and the debug/loader port (port 1, anti-starvation forced grant).
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   pX_req/we/addr/wdata             - request handshake for port X
//   pX_gnt                           - request accepted this cycle (combinational)
//   pX_rvalid                        - read data valid for port X, one cycle after grant
//   p0_stall                         - pipeline stall = p0_req & ~p0_gnt
//   rdata                            - shared read data, qualified by pX_rvalid
//   mem_read/write/addr/wdata/rdata  - data memory interface (rdata one cycle after read)
// Optional: define DMEM_ARB_PERF_EN to add perf_p0_cnt, perf_p1_cnt, perf_conflict_cnt.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = DMEM_ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]       perf_p0_cnt,
  output logic [15:0]       perf_p1_cnt,
  output logic [15:0]       perf_conflict_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  logic      force1;
  logic      rsp_pend_q;
  rsp_port_e rsp_port_q;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk   (clk),
    .rst   (rst),
    .p1_req(p1_req),
    .p1_gnt(p1_gnt),
    .force1(force1)
  );

  // Grants are suppressed during reset so nothing reaches memory.
  assign p1_gnt   = ~rst & p1_req & (~p0_req | force1);
  assign p0_gnt   = ~rst & p0_req & ~p1_gnt;
  assign p0_stall = p0_req & ~p0_gnt;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_read  = ~p0_we;
      mem_write = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_read  = ~p1_we;
      mem_write = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q <= 1'b0;
      rsp_port_q <= RspP0;
    end else begin
      rsp_pend_q <= mem_read;
      rsp_port_q <= p1_gnt ? RspP1 : RspP0;
    end
  end

  // Gating with rst drops a response that was in flight when reset arrived.
  assign p0_rvalid = ~rst & rsp_pend_q & (rsp_port_q == RspP0);
  assign p1_rvalid = ~rst & rsp_pend_q & (rsp_port_q == RspP1);
  assign rdata     = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_p0_cnt       <= '0;
      perf_p1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (p0_gnt)           perf_p0_cnt       <= perf_p0_cnt + 16'd1;
      if (p1_gnt)           perf_p1_cnt       <= perf_p1_cnt + 16'd1;
      if (p0_req && p1_req) perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 512 B data memory between two requesters: port 0 is the pipeline MEM stage; port 1 is the debug/loader port.
- Each port uses a valid/ready request handshake. Read data comes back one cycle after the grant, with a per-port response strobe.
- Port 0 has priority. A wait counter prevents port 1 from starving.
- Sits between the pipeline/debug logic and data_memory; drives the pipeline stall.

Parameters:
- ADDR_W, 9, byte address width into data memory
- DATA_W, 16, data word width
- MAX_WAIT, 4, consecutive cycles port 1 may be refused before it is forced through (range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  pipeline request valid
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_W  pipeline address
- p0_wdata  in  DATA_W  pipeline write data
- p0_gnt  out  1  pipeline request accepted this cycle
- p0_rvalid  out  1  pipeline read data valid
- p0_stall  out  1  = p0_req & ~p0_gnt (combinational)
- p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  debug port request (same meaning as port 0)
- p1_gnt  out  1  debug request accepted
- p1_rvalid  out  1  debug read data valid
- rdata  out  DATA_W  read data shared by both ports; qualified by pX_rvalid
- mem_read, mem_write  out  1  to data_memory
- mem_addr  out  ADDR_W  to data_memory
- mem_wdata  out  DATA_W  to data_memory
- mem_rdata  in  DATA_W  from data_memory; valid one cycle after mem_read

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: rst high at a clk edge forces all registered state to 0:
  - wait_cnt = 0, state = ARB, rsp_port = 0, rsp_pend = 0
  - p0_rvalid = p1_rvalid = 0
  - rdata holds its last value; it is don't-care while rvalid is low.
- Combinational outputs during reset:
  - gnt, mem_read and mem_write are forced to 0 while rst is high.
  - Any response pending at reset is dropped.
- Grant rule (combinational, same cycle as the request):
  - force1 = (wait_cnt == MAX_WAIT).
  - p1_gnt = p1_req & (~p0_req | force1).
  - p0_gnt = p0_req & ~p1_gnt.
  - At most one grant per cycle.
- Memory drive: the granted port's we/addr/wdata are muxed to the memory.
  - mem_read = gnt & ~we; mem_write = gnt & we.
  - With no grant, all memory outputs are 0.
- wait_cnt:
  - Increments when p1_req & ~p1_gnt, saturating at MAX_WAIT.
  - Clears when p1_gnt is high or p1_req is low.
- Read response:
  - A read granted in cycle N sets rsp_pend and rsp_port at edge N.
  - In cycle N+1: pX_rvalid = 1 for the granted port only, and rdata = mem_rdata (combinational pass-through).
  - Latency is exactly 1 cycle. Back-to-back reads are allowed with one grant per cycle.
- Writes:
  - Committed at the grant edge; no response strobe.
  - A read to the same address in the next cycle returns the new data (memory is write-first, then read).
- Requester rules:
  - A requester holds req/we/addr/wdata stable until gnt.
  - Dropping req before gnt is legal; the request is withdrawn.
- Boundary cases:
  - Simultaneous requests with wait_cnt < MAX_WAIT: port 0 wins.
  - Simultaneous requests with wait_cnt == MAX_WAIT: port 1 wins, and p0_stall is asserted for exactly that one cycle.
  - Address wraps modulo 2^ADDR_W. No bounds check is done.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs
  - perf_p0_cnt [15:0]: counts p0 grants
  - perf_p1_cnt [15:0]: counts p1 grants
  - perf_conflict_cnt [15:0]: counts cycles with both requests high
  - All three clear on rst and wrap at 0xFFFF → 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines file gets: DMEM_ADDR_W = 9, DMEM_DATA_W = 16, DMEM_ARB_MAX_WAIT default.
- One natural sub-module: dmem_arb_starve_ctr, the saturating wait counter producing force1. Everything else stays in the top module.

Test Plan:
- Reset: rst high for 2 cycles while both ports request.
  - During reset: no gnt, mem_read = mem_write = 0.
  - After release: wait_cnt = 0 and p0 is granted first.
- p0 write 0x1234 to 0x010, then p0 read of 0x010 in the next cycle.
  - p0_rvalid in the following cycle with rdata = 0x1234; p1_rvalid stays 0.
- p1 read alone at 0x1FF.
  - p1_gnt in the same cycle; p1_rvalid one cycle later.
- Starvation check with MAX_WAIT = 4: p0_req and p1_req both held high continuously.
  - p0 granted for 4 cycles, then p1 granted in cycle 5 with p0_stall = 1.
  - Pattern repeats every 5 cycles.
- Back-to-back reads: p0 reads 0x002 then p1 reads 0x004.
  - rvalid strobes land on consecutive cycles on the correct ports with the correct data.
- Mid-operation reset: rst asserted one cycle after a p1 read grant.
  - No p1_rvalid is produced; counters clear (perf counters too with DMEM_ARB_PERF_EN).
